// File: rtl/mult_seq_ctrl.sv
// Sequencer for an unsigned shift-and-add multiplier that borrows an external
// 32-bit ripple adder for WIDTH cycles per operation and returns a 2*WIDTH product.
module mult_seq_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product,
  output logic [WIDTH-1:0]   AddA,
  output logic [WIDTH-1:0]   AddB,
  output logic               AddCin,
  input  logic [WIDTH-1:0]   AddSum,
  input  logic               AddCout
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   m_reg;
  logic [2*WIDTH-1:0] p_reg;
  logic [2*WIDTH-1:0] p_next;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last_step;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    accept     = 1'b0;
    last_step  = 1'b0;
    AddA       = '0;
    AddB       = '0;
    AddCin     = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        Busy = 1'b1;
        AddA = p_reg[2*WIDTH-1:WIDTH];
        AddB = p_reg[0] ? m_reg : '0;
        if (cnt == CNT_LAST) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Carry-out lands in the MSB so the shifted sum never drops a bit.
  assign p_next = {AddCout, AddSum, p_reg[WIDTH-1:1]};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      m_reg   <= '0;
      p_reg   <= '0;
      cnt     <= '0;
      Product <= '0;
    end else if (accept) begin
      m_reg <= Multiplicand;
      p_reg <= {{WIDTH{1'b0}}, Multiplier};
      cnt   <= '0;
    end else if (state == RUN) begin
      p_reg <= p_next;
      cnt   <= cnt + 1'b1;
      if (last_step) begin
        Product <= p_next;
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl with a behavioural adder and a
// plain-arithmetic product/timing reference.
module tb_mult_seq_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;
  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic          add_cin;
  logic [W-1:0]  add_sum;
  logic          add_cout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Stand-in for the external Adder32
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .Clock        (clk),
    .Reset        (rst),
    .Start        (start),
    .Multiplicand (mcand),
    .Multiplier   (mplier),
    .Busy         (busy),
    .Done         (done),
    .Product      (product),
    .AddA         (add_a),
    .AddB         (add_b),
    .AddCin       (add_cin),
    .AddSum       (add_sum),
    .AddCout      (add_cout)
  );

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    return 64'(m) * 64'(q);
  endfunction

  // Issues one Start pulse and observes a bounded window; returns what it saw.
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input int cycles,
                        output int busy_cnt, output int done_cnt, output int done_at,
                        output logic [2*W-1:0] prod_done, output logic [2*W-1:0] prod_first,
                        output logic prod_stable, output logic cin_seen, output logic ab_seen);
    @(negedge clk);
    mcand = m; mplier = q; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    prod_done = 'x; prod_first = product;
    prod_stable = 1'b1; cin_seen = 1'b0; ab_seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (busy === 1'b1) begin
        busy_cnt++;
        if (product !== prod_first) prod_stable = 1'b0;
        if ((add_a | add_b) != '0) ab_seen = 1'b1;
      end
      if (add_cin !== 1'b0) cin_seen = 1'b1;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = c;
        prod_done = product;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; mcand = 32'hDEAD_BEEF; mplier = 32'h1234_5678;
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (product !== '0) begin n_fail++; $display("FAIL reset_product: got %h expected 0", product); end
    n_tests++; if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
      n_fail++; $display("FAIL reset_adder: got a=%h b=%h cin=%b expected all 0", add_a, add_b, add_cin);
    end
  endtask

  task automatic test_basic;
    int bc, dc, da; logic [2*W-1:0] pd, pf; logic ps, cs, abs;
    run_op(32'd3, 32'd5, 40, bc, dc, da, pd, pf, ps, cs, abs);
    n_tests++; if (bc != W) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, W); end
    n_tests++; if (dc != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", dc); end
    n_tests++; if (da != W) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected %0d", da, W); end
    n_tests++; if (pd !== 64'h0000_0000_0000_000F) begin n_fail++; $display("FAIL basic_product: got %h expected %h", pd, 64'hF); end
    n_tests++; if (cs !== 1'b0) begin n_fail++; $display("FAIL basic_cin: got %b expected 0", cs); end
  endtask

  task automatic test_max;
    int bc, dc, da; logic [2*W-1:0] pd, pf; logic ps, cs, abs;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 40, bc, dc, da, pd, pf, ps, cs, abs);
    n_tests++; if (pd !== 64'hFFFF_FFFE_0000_0001) begin
      n_fail++; $display("FAIL max_product: got %h expected %h", pd, 64'hFFFF_FFFE_0000_0001);
    end
    n_tests++; if (da != W) begin n_fail++; $display("FAIL max_done_cycle: got %0d expected %0d", da, W); end
  endtask

  task automatic test_zero;
    int bc, dc, da; logic [2*W-1:0] pd, pf; logic ps, cs, abs;
    run_op(32'h1234_5678, 32'd0, 40, bc, dc, da, pd, pf, ps, cs, abs);
    n_tests++; if (pd !== '0) begin n_fail++; $display("FAIL zero_product: got %h expected 0", pd); end
    n_tests++; if (bc != W) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d expected %0d", bc, W); end
    n_tests++; if (da != W) begin n_fail++; $display("FAIL zero_done_cycle: got %0d expected %0d", da, W); end
    n_tests++; if (abs !== 1'b0) begin n_fail++; $display("FAIL zero_adder_idle: got %b expected 0", abs); end
  endtask

  task automatic test_random;
    int bc, dc, da; logic [2*W-1:0] pd, pf; logic ps, cs, abs;
    logic [W-1:0] m, q;
    for (int i = 0; i < 10; i++) begin
      m = $urandom; q = $urandom;
      if (i == 0) q = 32'h8000_0001;
      run_op(m, q, 40, bc, dc, da, pd, pf, ps, cs, abs);
      n_tests++; if (pd !== ref_mul(m, q) || dc != 1 || da != W) begin
        n_fail++;
        $display("FAIL random_%0d %h*%h: got %h done=%0d at %0d expected %h done=1 at %0d",
                 i, m, q, pd, dc, da, ref_mul(m, q), W);
      end
    end
  endtask

  task automatic test_start_ignored;
    int dc_first, dc_total, da1, da2;
    logic [2*W-1:0] p1, p2, p_hold;
    logic b33, b34;
    dc_first = 0; dc_total = 0; da1 = -1; da2 = -1; p1 = 'x; p2 = 'x; p_hold = 'x; b33 = 1'bx; b34 = 1'bx;
    @(negedge clk);
    mcand = 32'd7; mplier = 32'd9; start = 1'b1;
    @(negedge clk);
    mcand = 32'd11; mplier = 32'd13;
    for (int c = 0; c < 70; c++) begin
      if (c == 33) begin b33 = busy; p_hold = product; end
      if (c == 34) begin b34 = busy; start = 1'b0; end
      if (done === 1'b1) begin
        dc_total++;
        if (c <= 33) begin dc_first++; da1 = c; p1 = product; end
        else begin da2 = c; p2 = product; end
      end
      @(negedge clk);
    end
    n_tests++; if (p1 !== 64'd63 || da1 != W || dc_first != 1) begin
      n_fail++; $display("FAIL ignored_first: got %0d at %0d count %0d expected 63 at %0d count 1", p1, da1, dc_first, W);
    end
    n_tests++; if (p_hold !== 64'd63) begin n_fail++; $display("FAIL ignored_hold: got %0d expected 63", p_hold); end
    n_tests++; if (b33 !== 1'b0 || b34 !== 1'b1) begin
      n_fail++; $display("FAIL ignored_restart: got busy33=%b busy34=%b expected 0 1", b33, b34);
    end
    n_tests++; if (p2 !== 64'd143 || da2 != 66 || dc_total != 2) begin
      n_fail++; $display("FAIL ignored_second: got %0d at %0d total %0d expected 143 at 66 total 2", p2, da2, dc_total);
    end
  endtask

  task automatic test_reset_mid;
    int bc, dc, da; logic [2*W-1:0] pd, pf; logic ps, cs, abs;
    int done_seen;
    logic b10;
    @(negedge clk);
    mcand = $urandom | 32'h1; mplier = $urandom | 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    b10 = busy;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (b10 !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_busy: got before=%b after=%b expected 1 0", b10, busy);
    end
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) done_seen++;
      @(negedge clk);
    end
    n_tests++; if (done_seen != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d expected 0", done_seen); end
    n_tests++; if (product !== '0) begin n_fail++; $display("FAIL midreset_product: got %h expected 0", product); end
    run_op(32'h0001_0000, 32'h0001_0000, 40, bc, dc, da, pd, pf, ps, cs, abs);
    n_tests++; if (pd !== 64'h0000_0001_0000_0000) begin
      n_fail++; $display("FAIL midreset_next: got %h expected %h", pd, 64'h0000_0001_0000_0000);
    end
  endtask

  task automatic test_back_to_back;
    int bc, dc, da; logic [2*W-1:0] pd, pf; logic ps, cs, abs;
    run_op(32'd2, 32'd2, 40, bc, dc, da, pd, pf, ps, cs, abs);
    n_tests++; if (pd !== 64'd4) begin n_fail++; $display("FAIL b2b_first: got %0d expected 4", pd); end
    repeat (3) @(negedge clk);
    n_tests++; if (product !== 64'd4) begin n_fail++; $display("FAIL b2b_idle_hold: got %0d expected 4", product); end
    run_op(32'd6, 32'd7, 40, bc, dc, da, pd, pf, ps, cs, abs);
    n_tests++; if (pf !== 64'd4 || ps !== 1'b1) begin
      n_fail++; $display("FAIL b2b_stale: got first=%0d stable=%b expected 4 1", pf, ps);
    end
    n_tests++; if (pd !== 64'd42) begin n_fail++; $display("FAIL b2b_second: got %0d expected 42", pd); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
